// File: rtl/alu_pkg.sv
// Shared ALU definitions for the LEGv8 datapath.
// Holds the nibble-serial adder state encoding and its default sizing constants.
package alu_pkg;

  // Default datapath width; the adder itself takes WIDTH as a parameter.
  localparam int unsigned NSA_WIDTH   = 64;
  localparam int unsigned NSA_NIBBLES = NSA_WIDTH / 4;
  localparam int unsigned NSA_IDX_W   = $clog2(NSA_NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

endpackage

// File: rtl/CLA_4bit.sv
// 4-bit carry-lookahead adder slice (purely combinational).
// Ports:
//   A, B  : 4-bit addends
//   Cin   : carry in
//   S     : 4-bit sum
//   Cout  : carry out of bit 3
module CLA_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = A & B;
  assign p = A ^ B;

  // Flattened lookahead terms so no carry ripples through the slice.
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign S    = p ^ c[3:0];
  assign Cout = c[4];

endmodule

// File: rtl/nibble_serial_adder64.sv
// Multi-cycle add/subtract unit: pushes one nibble per cycle through a CLA_4bit
// slice, keeps the ripple carry in a register and produces N/Z/C/V on completion.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, sub, a, b    : request, 0=A+B / 1=A-B, operands (sampled when not busy)
//   busy                : nibbles in flight
//   done                : one-cycle pulse, result and flags valid
//   result              : sum/difference, held until next accepted start
//   flag_n/z/c/v        : negative, zero, carry-out (1 = no borrow on SUB), overflow
module nibble_serial_adder64
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = NSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  nsa_state_t       state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic             n_q, z_q, c_q, v_q;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] nib_s;
  logic       nib_cout;
  logic       accept;
  logic       last;

  // New work is taken in IDLE and DONE; requests during RUN are dropped.
  assign accept = start && (state_q != RUN);
  assign last   = (idx_q == LAST_IDX);

  assign nib_a = opa_q[{idx_q, 2'b00} +: 4];
  assign nib_b = opb_q[{idx_q, 2'b00} +: 4];

  CLA_4bit u_cla (
    .A    (nib_a),
    .B    (nib_b),
    .Cin  (carry_q),
    .S    (nib_s),
    .Cout (nib_cout)
  );

  // Result with the current nibble merged in; flags are taken from this on the last nibble.
  always_comb begin
    result_d = result_q;
    result_d[{idx_q, 2'b00} +: 4] = nib_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else if (accept) begin
      state_q  <= RUN;
      idx_q    <= '0;
      carry_q  <= sub;              // the +1 of two's-complement subtract
      opa_q    <= a;
      opb_q    <= b ^ {WIDTH{sub}};
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else if (state_q == RUN) begin
      result_q <= result_d;
      carry_q  <= nib_cout;
      if (last) begin
        state_q <= DONE;
        idx_q   <= '0;
        n_q     <= result_d[WIDTH-1];
        z_q     <= (result_d == '0);
        c_q     <= nib_cout;
        v_q     <= (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                   (result_d[WIDTH-1] != opa_q[WIDTH-1]);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end else begin
      // DONE without a new request, or an unused encoding.
      state_q <= IDLE;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign flag_n = n_q;
  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_v = v_q;

endmodule

// File: doc/nibble_serial_adder64.md
# nibble_serial_adder64

Multi-cycle 64-bit add/subtract unit for the LEGv8 datapath. It feeds the existing 4-bit carry-lookahead adder slice one nibble per cycle, registers the ripple carry between nibbles, and assembles the full result. When done it also produces the ADDS/SUBS condition flags (N, Z, C, V). It sits directly upstream of the `CLA_4bit` slice, which it instantiates and drives, and downstream of the register-file read stage.

## Interface
Parameters:
- `WIDTH`, 64, operand width in bits; must be a multiple of 4.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request; sampled only when `busy`=0.
- `sub` input 1: 0 = A+B, 1 = A−B (two's complement, A + ~B + 1).
- `a` input WIDTH: operand A; sampled with `start`.
- `b` input WIDTH: operand B; sampled with `start`.
- `busy` output 1: high while nibbles are being processed.
- `done` output 1: one-cycle pulse when `result` and flags are valid.
- `result` output WIDTH: sum/difference; held until next accepted `start`.
- `flag_n`, `flag_z`, `flag_c`, `flag_v` output 1 each: negative, zero, carry-out, signed overflow.

## Operation
- States:
  - IDLE: reset state.
  - RUN: one nibble per cycle.
  - DONE: one cycle; `done`=1.
- Accept in IDLE or DONE when `start`=1. On acceptance:
  - Latch `a` into `opa` and `b ^ {WIDTH{sub}}` into `opb`.
  - Set carry register = `sub`, nibble index = 0, and clear `result`.
  - Go to RUN.
- RUN, each cycle:
  - Drive CLA slice with `opa[4i+:4]`, `opb[4i+:4]`, `Cin`=carry.
  - Write `S` into `result[4i+:4]`, set carry ← `Cout`, i ← i+1.
  - After nibble WIDTH/4−1, go to DONE.
- Flags are registered on entry to DONE and held with `result`:
  - N = `result[WIDTH-1]`.
  - Z = (`result`==0).
  - C = final carry. This is the ARM convention, so for SUB, C=1 means no borrow.
  - V = (`opa[MSB]`==`opb[MSB]`) && (`result[MSB]`!=`opa[MSB]`).
- From DONE:
  - Go to IDLE if `start`=0.
  - Go to RUN, accepting new operands, if `start`=1.
- `start` in RUN is ignored; no queueing.
- `a`, `b`, `sub` may change freely after acceptance.
- Nibble index wraps only via state transition and never exceeds WIDTH/4−1.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE; `busy`=0, `done`=0, `result`=0, all flags 0, carry=0, index=0.
- Reset mid-RUN aborts the operation. No `done` is produced.
- Latency: start accepted at edge E.
  - `busy`=1 from after E through edge E+WIDTH/4.
  - `done`=1 for exactly the cycle after edge E+WIDTH/4, i.e. WIDTH/4+1 cycles after the request cycle (17 for WIDTH=64).
- Throughput: back-to-back `start` held during DONE gives one result every WIDTH/4+1 cycles.
- `busy` and `done` are never high simultaneously.
- `result` bits change only during RUN. Consumers read on `done`.

## Structure
- Shared package `alu_pkg`:
  - state enum `nsa_state_t` {IDLE, RUN, DONE}.
  - constant `NSA_NIBBLES` = WIDTH/4.
  - index width `$clog2(NSA_NIBBLES)`.
- One sub-module instance: existing `CLA_4bit`, purely combinational, between operand/carry registers and the result register.
- Remaining logic is the FSM, index counter, operand/result/carry/flag registers, and nibble mux/demux: roughly 150–250 lines.

## Test plan
- Reset with `rst_n`=0 mid-operation -> outputs all 0, state IDLE; after release, no `done` pulse.
- a=5, b=3, sub=1 -> after 17 cycles `done`=1, `result`=2, N=0 Z=0 C=1 V=0.
- a=0, b=1, sub=1 -> `result`=0xFFFF_FFFF_FFFF_FFFF, N=1 Z=0 C=0 V=0.
- a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> `result`=0x8000_0000_0000_0000, N=1 V=1 C=0.
- a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0 -> `result`=0, Z=1 C=1 V=0.
- Hold `start`=1 continuously with new operands every cycle:
  - exactly one `done` per 17 cycles;
  - each result matches the operands present at its acceptance edge;
  - operand changes during RUN have no effect.
